// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage holding the PC, the fetch register and the start/done handshake.
// Optional run-cycle counter on cycle_count is built only when FETCH_CYCLE_COUNT_EN is defined.
module instr_fetch #(
  parameter int unsigned        PC_W       = 10,
  parameter int unsigned        INSTR_W    = 9,
  parameter logic [PC_W-1:0]    START_ADDR = '0,
  parameter logic [INSTR_W-1:0] NOP_WORD   = '0
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stall,
  input  logic               halt,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               done,
  output logic [15:0]        cycle_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      fetch_pc_q, fetch_pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;

  logic                 advance;
  logic                 take_halt;
  logic                 take_branch;
  logic                 launch;

  // Control qualifiers: a stalled or bubble cycle never acts on halt/branch.
  always_comb begin
    advance     = (state_q == S_RUN) && !stall;
    take_halt   = advance && valid_q && halt;
    take_branch = advance && valid_q && branch_taken && !halt;
    launch      = (state_q != S_RUN) && start;
  end

  // State register
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (take_halt) state_d = S_HALTED;
      end
      S_HALTED: begin
        if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: priority halt > branch > sequential fetch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    done_d     = (state_d == S_HALTED);
    if (launch) begin
      fetch_pc_d = START_ADDR;
      valid_d    = 1'b0;
    end else if (advance) begin
      if (take_halt) begin
        valid_d = 1'b0;
      end else if (take_branch) begin
        fetch_pc_d = branch_target;
        instr_d    = NOP_WORD;
        valid_d    = 1'b0;
      end else begin
        instr_d    = imem_data;
        pc_d       = fetch_pc_q;
        valid_d    = 1'b1;
        fetch_pc_d = fetch_pc_q + PC_W'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= START_ADDR;
      instr_q    <= NOP_WORD;
      pc_q       <= START_ADDR;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign done        = done_q;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts every RUN cycle (stalls and bubbles included), saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (launch) begin
      cnt_d = '0;
    end else if ((state_q == S_RUN) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scoreboard bench for instr_fetch (default START_ADDR and START_ADDR=3FE).
module tb_instr_fetch;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 9;
`ifdef FETCH_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                reset_n, start, start2, stall, halt, branch_taken;
  logic [PC_W-1:0]     branch_target;
  logic [PC_W-1:0]     imem_addr, imem_addr2, pc, pc2;
  logic [INSTR_W-1:0]  imem_data, imem_data2, instr, instr2;
  logic                instr_valid, instr_valid2, done, done2;
  logic [15:0]         cycle_count, cycle_count2;
  logic [INSTR_W-1:0]  imem [1024];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            tag;
    logic [PC_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic             valid;
    logic             done;
    logic [PC_W-1:0]  addr;
    logic             chk_pc;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  assign imem_data  = imem[imem_addr];
  assign imem_data2 = imem[imem_addr2];

  instr_fetch dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .done(done), .cycle_count(cycle_count)
  );

  instr_fetch #(.START_ADDR(10'h3FE)) dut_hi (
    .CLK(CLK), .reset_n(reset_n), .start(start2), .stall(1'b0), .halt(1'b0),
    .branch_taken(1'b0), .branch_target(10'h000),
    .imem_addr(imem_addr2), .imem_data(imem_data2), .instr(instr2),
    .instr_valid(instr_valid2), .pc(pc2), .done(done2), .cycle_count(cycle_count2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Push the expected post-edge view, advance one edge, pop and compare.
  task automatic cyc(input string tag, input logic [PC_W-1:0] e_pc,
                     input logic [INSTR_W-1:0] e_instr, input logic e_v,
                     input logic e_d, input logic [PC_W-1:0] e_addr,
                     input logic chk_pc);
    exp_t e;
    e.tag = tag; e.pc = e_pc; e.instr = e_instr; e.valid = e_v;
    e.done = e_d; e.addr = e_addr; e.chk_pc = chk_pc;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    if (e.chk_pc) check({e.tag, ".pc"}, 16'(pc), 16'(e.pc));
    check({e.tag, ".instr"}, 16'(instr), 16'(e.instr));
    check({e.tag, ".valid"}, 16'(instr_valid), 16'(e.valid));
    check({e.tag, ".done"}, 16'(done), 16'(e.done));
    check({e.tag, ".addr"}, 16'(imem_addr), 16'(e.addr));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = INSTR_W'(i * 5 + 7);
    imem[0] = 9'h011; imem[1] = 9'h022; imem[2] = 9'h033; imem[3] = 9'h044;
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; stall = 1'b0;
    halt = 1'b0; branch_taken = 1'b0; branch_target = '0;

    tick(); tick();
    check("rst.pc", 16'(pc), 16'h000);
    check("rst.instr", 16'(instr), 16'h000);
    check("rst.valid", 16'(instr_valid), 16'h0);
    check("rst.done", 16'(done), 16'h0);
    check("rst.addr", 16'(imem_addr), 16'h000);
    check("rst.cnt", cycle_count, 16'h0);
    check("rst.hi.pc", 16'(pc2), 16'h3FE);
    check("rst.hi.addr", 16'(imem_addr2), 16'h3FE);
    check("rst.hi.cnt", cycle_count2, 16'h0);
    #2 reset_n = 1'b1;

    cyc("idle", 10'h000, 9'h000, 1'b0, 1'b0, 10'h000, 1'b1);
    start = 1'b1; start2 = 1'b1;
    cyc("start", 10'h000, 9'h000, 1'b0, 1'b0, 10'h000, 1'b1);
    start = 1'b0; start2 = 1'b0;
    cyc("f0", 10'h000, 9'h011, 1'b1, 1'b0, 10'h001, 1'b1);
    check("hi.f0.pc", 16'(pc2), 16'h3FE);
    check("hi.f0.instr", 16'(instr2), 16'(imem[10'h3FE]));
    check("hi.f0.valid", 16'(instr_valid2), 16'h1);
    cyc("f1", 10'h001, 9'h022, 1'b1, 1'b0, 10'h002, 1'b1);
    check("hi.f1.pc", 16'(pc2), 16'h3FF);
    cyc("f2", 10'h002, 9'h033, 1'b1, 1'b0, 10'h003, 1'b1);
    check("hi.wrap.pc", 16'(pc2), 16'h000);
    check("hi.wrap.instr", 16'(instr2), 16'h011);
    check("hi.done", 16'(done2), 16'h0);

    // Taken branch at pc=2; branch held during the bubble must be ignored.
    branch_taken = 1'b1; branch_target = 10'h040;
    cyc("br.bubble", 10'h000, 9'h000, 1'b0, 1'b0, 10'h040, 1'b0);
    branch_target = 10'h100;
    cyc("br.tgt", 10'h040, imem[10'h040], 1'b1, 1'b0, 10'h041, 1'b1);
    branch_taken = 1'b0;
    cyc("br.seq", 10'h041, imem[10'h041], 1'b1, 1'b0, 10'h042, 1'b1);
    branch_taken = 1'b1; branch_target = 10'h003;
    cyc("br2.bubble", 10'h000, 9'h000, 1'b0, 1'b0, 10'h003, 1'b0);
    branch_taken = 1'b0;
    cyc("f3", 10'h003, 9'h044, 1'b1, 1'b0, 10'h004, 1'b1);
    cyc("f4", 10'h004, imem[10'h004], 1'b1, 1'b0, 10'h005, 1'b1);
    cyc("f5", 10'h005, imem[10'h005], 1'b1, 1'b0, 10'h006, 1'b1);

    // Halt beats a simultaneous branch.
    halt = 1'b1; branch_taken = 1'b1; branch_target = 10'h200;
    cyc("halt", 10'h005, imem[10'h005], 1'b0, 1'b1, 10'h006, 1'b1);
    halt = 1'b0; branch_taken = 1'b0;
    cyc("halted", 10'h005, imem[10'h005], 1'b0, 1'b1, 10'h006, 1'b1);
    stall = 1'b1;
    cyc("halted.stall", 10'h005, imem[10'h005], 1'b0, 1'b1, 10'h006, 1'b1);
    stall = 1'b0;
    start = 1'b1;
    cyc("restart", 10'h005, imem[10'h005], 1'b0, 1'b0, 10'h000, 1'b1);
    start = 1'b0;
    cyc("re.f0", 10'h000, 9'h011, 1'b1, 1'b0, 10'h001, 1'b1);
    for (int n = 1; n <= 7; n++)
      cyc("seq", PC_W'(n), imem[n], 1'b1, 1'b0, PC_W'(n + 1), 1'b1);

    // Stall three cycles at pc=7 with halt asserted.
    stall = 1'b1; halt = 1'b1;
    for (int k = 0; k < 3; k++)
      cyc("stall", 10'h007, imem[10'h007], 1'b1, 1'b0, 10'h008, 1'b1);
    stall = 1'b0; halt = 1'b0;
    cyc("post.stall", 10'h008, imem[10'h008], 1'b1, 1'b0, 10'h009, 1'b1);
    start = 1'b1;
    cyc("start.in.run", 10'h009, imem[10'h009], 1'b1, 1'b0, 10'h00A, 1'b1);
    start = 1'b0;

    // Branch to the top address; halt during the bubble is ignored; PC wraps.
    branch_taken = 1'b1; branch_target = 10'h3FF;
    cyc("br3.bubble", 10'h000, 9'h000, 1'b0, 1'b0, 10'h3FF, 1'b0);
    branch_taken = 1'b0; halt = 1'b1;
    cyc("wrap.a", 10'h3FF, imem[10'h3FF], 1'b1, 1'b0, 10'h000, 1'b1);
    halt = 1'b0;
    cyc("wrap.b", 10'h000, 9'h011, 1'b1, 1'b0, 10'h001, 1'b1);
    halt = 1'b1;
    cyc("halt2", 10'h000, 9'h011, 1'b0, 1'b1, 10'h001, 1'b1);
    halt = 1'b0;
    check("halt2.cnt", cycle_count, CNT_EN ? 16'd17 : 16'd0);

    // Asynchronous reset in the middle of a RUN cycle.
    start = 1'b1;
    cyc("re2", 10'h000, 9'h011, 1'b0, 1'b0, 10'h000, 1'b1);
    start = 1'b0;
    cyc("re2.f0", 10'h000, 9'h011, 1'b1, 1'b0, 10'h001, 1'b1);
    cyc("re2.f1", 10'h001, 9'h022, 1'b1, 1'b0, 10'h002, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst.pc", 16'(pc), 16'h000);
    check("arst.instr", 16'(instr), 16'h000);
    check("arst.valid", 16'(instr_valid), 16'h0);
    check("arst.addr", 16'(imem_addr), 16'h000);
    check("arst.cnt", cycle_count, 16'h0);
    tick();
    #2 reset_n = 1'b1;
    cyc("post.rst", 10'h000, 9'h000, 1'b0, 1'b0, 10'h000, 1'b1);

    // Twenty RUN cycles ending in halt, then hold.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 19; k++) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("cnt.done", 16'(done), 16'h1);
    check("cnt.20", cycle_count, CNT_EN ? 16'd20 : 16'd0);
    tick(); tick();
    check("cnt.hold", cycle_count, CNT_EN ? 16'd20 : 16'd0);
    check("cnt.pc", 16'(pc), 16'd18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
